// File: rtl/ac_sweep_sequencer.sv
// Stepped-frequency AC sweep sequencer: program NCO, settle, accumulate navg ADC samples, return sum.
// Optional macro SWEEP_LOG_EN: geometric sweep (fword scaled by a Q16.16 ratio in an extra STEP cycle).
module ac_sweep_sequencer #(
    parameter int FW_W     = 32,
    parameter int DATA_W   = 16,
    parameter int NPTS_W   = 10,
    parameter int SETTLE_W = 16,
    parameter int AVG_W    = 8,
    parameter int ACC_W    = DATA_W + AVG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [FW_W-1:0]     cfg_fstart,
    input  logic [FW_W-1:0]     cfg_fstep,
    input  logic [NPTS_W-1:0]   cfg_npts,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic [AVG_W-1:0]    cfg_navg,
    output logic [FW_W-1:0]     nco_fword,
    output logic                nco_load,
    input  logic                adc_valid,
    input  logic [DATA_W-1:0]   adc_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    res_data,
    output logic [NPTS_W-1:0]   res_index,
    output logic                busy,
    output logic                done
);

    // Result port: a transfer happens on every rising edge where res_valid && res_ready;
    // res_data/res_index are held stable while res_valid is high and res_ready is low.
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_ACQ, S_OUT, S_STEP, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [FW_W-1:0]     fword, fstep_q;
    logic [NPTS_W-1:0]   npts_q, index;
    logic [SETTLE_W-1:0] settle_q, settle_cnt;
    logic [AVG_W-1:0]    navg_q, samp_cnt;
    logic [ACC_W-1:0]    acc;
    logic                last_sample, last_point;

    // navg_q already has 0 mapped to 1, so navg_q-1 never underflows.
    assign last_sample = (samp_cnt == navg_q - AVG_W'(1));
    assign last_point  = (index == npts_q - NPTS_W'(1));

`ifdef SWEEP_LOG_EN
    logic [FW_W+31:0] prod;
    assign prod = (FW_W+32)'(fword) * (FW_W+32)'(fstep_q);
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = (cfg_npts == '0) ? S_DONE : S_LOAD;
            S_LOAD:   state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == '0) state_nxt = S_ACQ;
            S_ACQ:    if (adc_valid && last_sample) state_nxt = S_OUT;
            S_OUT: begin
                if (res_ready) begin
`ifdef SWEEP_LOG_EN
                    state_nxt = last_point ? S_DONE : S_STEP;
`else
                    state_nxt = last_point ? S_DONE : S_LOAD;
`endif
                end
            end
            S_STEP:   state_nxt = S_LOAD;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fword      <= '0;
            fstep_q    <= '0;
            npts_q     <= '0;
            settle_q   <= '0;
            navg_q     <= '0;
            index      <= '0;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            acc        <= '0;
            nco_fword  <= '0;
            nco_load   <= 1'b0;
        end else begin
            nco_load <= 1'b0;
            // abort blocks every datapath update, including the NCO strobe.
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            fword    <= cfg_fstart;
                            fstep_q  <= cfg_fstep;
                            npts_q   <= cfg_npts;
                            settle_q <= cfg_settle;
                            navg_q   <= (cfg_navg == '0) ? AVG_W'(1) : cfg_navg;
                            index    <= '0;
                        end
                    end
                    S_LOAD: begin
                        nco_fword  <= fword;
                        nco_load   <= 1'b1;
                        acc        <= '0;
                        samp_cnt   <= '0;
                        settle_cnt <= settle_q;
                    end
                    S_SETTLE: begin
                        if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
                    end
                    S_ACQ: begin
                        if (adc_valid) begin
                            acc      <= acc + {{AVG_W{adc_data[DATA_W-1]}}, adc_data};
                            samp_cnt <= samp_cnt + AVG_W'(1);
                        end
                    end
                    S_OUT: begin
                        if (res_ready && !last_point) begin
                            index <= index + NPTS_W'(1);
`ifndef SWEEP_LOG_EN
                            fword <= fword + fstep_q;
`endif
                        end
                    end
                    S_STEP: begin
`ifdef SWEEP_LOG_EN
                        fword <= prod[FW_W+15:16];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign res_valid = (state == S_OUT);
    assign res_data  = acc;
    assign res_index = index;

endmodule
